// File: rtl/hazard_scoreboard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard_pkg
//
// Shared definitions for the decode-stage hazard scoreboard.
//
// Contents:
//   - Default sizing constants for the scoreboard parameters.
//   - reg_addr_t : register-number type for the default address width.
//   - cnt_max()  : largest value a pending counter of a given width can hold,
//                  which is also the point where further writes must stall.
//   - op_class_e / reg_write_fn() : decode helper. Decode uses it to produce
//                  id_dst_we from the instruction class.
//
// Configuration macro (consumed by hazard_scoreboard.sv):
//   HAZARD_SCOREBOARD_WAW_EN - stall a writer while its destination is still
//                              pending, which enforces write-after-write order.
// ----------------------------------------------------------------------------
package hazard_scoreboard_pkg;

    localparam int NUM_REGS_DEF = 16;
    localparam int REG_AW_DEF   = 4;
    localparam int NUM_SRC_DEF  = 2;
    localparam int CNT_W_DEF    = 2;

    typedef logic [REG_AW_DEF-1:0] reg_addr_t;

    // Instruction classes as decode sees them.
    typedef enum logic [2:0] {
        OP_ALU     = 3'd0,
        OP_ALU_IMM = 3'd1,
        OP_LOAD    = 3'd2,
        OP_STORE   = 3'd3,
        OP_BRANCH  = 3'd4,
        OP_JAL     = 3'd5,
        OP_SYSTEM  = 3'd6,
        OP_NOP     = 3'd7
    } op_class_e;

    // Saturation point of a pending counter of width cntW.
    function automatic int cnt_max(input int cntW);
        return (1 << cntW) - 1;
    endfunction

    // Classes that write a destination register.
    function automatic logic reg_write_fn(input op_class_e op);
        logic writes;
        case (op)
            OP_ALU, OP_ALU_IMM, OP_LOAD, OP_JAL: writes = 1'b1;
            default:                             writes = 1'b0;
        endcase
        return writes;
    endfunction

endpackage

// File: rtl/hazard_sb_counter.sv
// ----------------------------------------------------------------------------
// hazard_sb_counter
//
// Pending-write counter for one architectural register. The issue increment
// and up to two retire/kill decrements arrive in the same cycle. They are
// combined into a single net update, and the result is clamped at zero.
//
// Ports:
//   clk          in  clock, rising edge
//   rst_n        in  asynchronous active-low reset, clears the count
//   inc_i        in  an accepted issue writes this register
//   dec_i[1:0]   in  number of writes retired or killed this cycle (0..2)
//   busy_o       out count is non-zero
//   sat_o        out count is at its maximum; no further issue is allowed
//   underflow_o  out net decrement exceeds the count this cycle
// ----------------------------------------------------------------------------
module hazard_sb_counter
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_i,
    input  logic [1:0] dec_i,
    output logic       busy_o,
    output logic       sat_o,
    output logic       underflow_o
);

    localparam logic [CNT_W:0] MaxExt = (CNT_W+1)'(cnt_max(CNT_W));

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   sumExt;
    logic [CNT_W:0]   decExt;
    logic [CNT_W:0]   diffExt;

    // The increment is added before the decrements are taken away. A counter
    // at 0 that gets an issue and a retire in the same cycle is therefore
    // legal and stays at 0. The upper clamp is defensive only, because the
    // top level never issues into a saturated counter.
    always_comb begin
        sumExt      = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inc_i};
        decExt      = (CNT_W+1)'(dec_i);
        diffExt     = sumExt - decExt;
        underflow_o = (decExt > sumExt);
        cnt_d       = cnt_q;
        if (underflow_o) begin
            cnt_d = '0;
        end else if (diffExt > MaxExt) begin
            cnt_d = MaxExt[CNT_W-1:0];
        end else begin
            cnt_d = diffExt[CNT_W-1:0];
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = |cnt_q;
    assign sat_o  = &cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard
//
// RAW and structural hazard detector for the decode stage. Each register has
// a counter of in-flight writes, so the pipeline may have any depth and may
// hold several outstanding writes to the same register.
//
// Ports:
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   id_valid       decode holds a valid instruction
//   id_src_addr    source register numbers; port k is at [k*REG_AW +: REG_AW]
//   id_src_used    bit k: source port k is actually read
//   id_dst_addr    destination register
//   id_dst_we      instruction writes id_dst_addr
//   id_issue       decode attempts to hand the instruction to EX
//   wb_valid/addr  a register write retires
//   kill_valid/addr an issued writer was squashed and will never retire
//   stall          hold IF/ID; the issue is not accepted
//   busy_mask      bit r: register r has pending writes
//   err_sticky     counter underflow seen since reset
//
// Configuration macro:
//   HAZARD_SCOREBOARD_WAW_EN - also stall while the destination is pending.
//
// Register numbers at or above NUM_REGS match no counter. They never stall and
// they never change state.
// ----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int REG_AW   = REG_AW_DEF,
    parameter int NUM_SRC  = NUM_SRC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [REG_AW-1:0]         id_dst_addr,
    input  logic                      id_dst_we,
    input  logic                      id_issue,
    input  logic                      wb_valid,
    input  logic [REG_AW-1:0]         wb_addr,
    input  logic                      kill_valid,
    input  logic [REG_AW-1:0]         kill_addr,
    output logic                      stall,
    output logic [NUM_REGS-1:0]       busy_mask,
    output logic                      err_sticky
);

    logic [NUM_REGS-1:0] incVec;
    logic [NUM_REGS-1:0] busyVec;
    logic [NUM_REGS-1:0] satVec;
    logic [NUM_REGS-1:0] uflVec;
    logic [1:0]          decCnt [NUM_REGS];
    logic                srcHit;
    logic                dstSat;
`ifdef HAZARD_SCOREBOARD_WAW_EN
    logic                dstBusy;
`endif
    logic                issueAcc;
    logic                errSticky_q;
    logic                errSticky_d;

    // Hazard lookup. Registers are matched with equality only, so an address
    // outside the tracked range hits nothing. Counters are registered, so a
    // write retired this cycle releases its readers in the next cycle.
    always_comb begin
        srcHit = 1'b0;
        dstSat = 1'b0;
`ifdef HAZARD_SCOREBOARD_WAW_EN
        dstBusy = 1'b0;
`endif
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (id_src_used[k] &&
                    (id_src_addr[k*REG_AW +: REG_AW] == REG_AW'(r)) &&
                    busyVec[r]) begin
                    srcHit = 1'b1;
                end
            end
        end
        for (int r = 0; r < NUM_REGS; r++) begin
            if (id_dst_addr == REG_AW'(r)) begin
                dstSat = satVec[r];
`ifdef HAZARD_SCOREBOARD_WAW_EN
                dstBusy = busyVec[r];
`endif
            end
        end
    end

    // A saturated destination stalls because one more write could not be
    // counted. With WAW enforcement, any pending write to the destination
    // also stalls.
    always_comb begin
`ifdef HAZARD_SCOREBOARD_WAW_EN
        stall = id_valid && (srcHit || (id_dst_we && (dstSat || dstBusy)));
`else
        stall = id_valid && (srcHit || (id_dst_we && dstSat));
`endif
        issueAcc = id_valid && id_issue && !stall && id_dst_we;
    end

    // Per-register events for this cycle. A retire and a kill of the same
    // register add together into a decrement of 2.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            incVec[r] = issueAcc && (id_dst_addr == REG_AW'(r));
            decCnt[r] = {1'b0, wb_valid && (wb_addr == REG_AW'(r))} +
                        {1'b0, kill_valid && (kill_addr == REG_AW'(r))};
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : gen_cnt
        hazard_sb_counter #(
            .CNT_W       (CNT_W)
        ) u_cnt (
            .clk         (clk),
            .rst_n       (rst_n),
            .inc_i       (incVec[g]),
            .dec_i       (decCnt[g]),
            .busy_o      (busyVec[g]),
            .sat_o       (satVec[g]),
            .underflow_o (uflVec[g])
        );
    end

    // Underflow means the pipeline retired or killed a write that was never
    // issued. The flag latches until reset so that a monitor can see it.
    always_comb begin
        errSticky_d = errSticky_q | (|uflVec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errSticky_q <= 1'b0;
        end else begin
            errSticky_q <= errSticky_d;
        end
    end

    assign busy_mask  = busyVec;
    assign err_sticky = errSticky_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Directed bench for hazard_scoreboard with the default parameters
// (16 registers, 2 source ports, 2-bit counters). Expected values are worked
// out by hand from the counter contents each step builds up.
// ----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [7:0]  id_src_addr;
    logic [1:0]  id_src_used;
    logic [3:0]  id_dst_addr;
    logic        id_dst_we;
    logic        id_issue;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic        kill_valid;
    logic [3:0]  kill_addr;
    logic        stall;
    logic [15:0] busy_mask;
    logic        err_sticky;

    int checkCount = 0;
    int passCount  = 0;

`ifdef HAZARD_SCOREBOARD_WAW_EN
    localparam logic WawStallExp = 1'b1;
`else
    localparam logic WawStallExp = 1'b0;
`endif

    hazard_scoreboard dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_src_addr (id_src_addr),
        .id_src_used (id_src_used),
        .id_dst_addr (id_dst_addr),
        .id_dst_we   (id_dst_we),
        .id_issue    (id_issue),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .kill_valid  (kill_valid),
        .kill_addr   (kill_addr),
        .stall       (stall),
        .busy_mask   (busy_mask),
        .err_sticky  (err_sticky)
    );

    // 10 time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end else begin
            passCount++;
        end
    endtask

    // Drive every DUT input in one step, then let combinational logic settle.
    task automatic applyStimulus(input int valid, input int srcAddr, input int srcUsed,
                                 input int dstAddr, input int dstWe, input int issue,
                                 input int wbV, input int wbA, input int killV,
                                 input int killA);
        id_valid    = 1'(valid);
        id_src_addr = 8'(srcAddr);
        id_src_used = 2'(srcUsed);
        id_dst_addr = 4'(dstAddr);
        id_dst_we   = 1'(dstWe);
        id_issue    = 1'(issue);
        wb_valid    = 1'(wbV);
        wb_addr     = 4'(wbA);
        kill_valid  = 1'(killV);
        kill_addr   = 4'(killA);
        #1;
    endtask

    // Advance one rising edge and sample just after it.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("rst_busy", 32'(busy_mask), 32'h0);
        checkOutput("rst_stall", 32'(stall), 32'h0);
        checkOutput("rst_err", 32'(err_sticky), 32'h0);
        #4;
        rst_n = 1'b1;
        stepClock();

        // RAW on r5, released one cycle after the write-back.
        applyStimulus(1, 0, 0, 5, 1, 1, 0, 0, 0, 0);
        checkOutput("raw_first_issue_stall", 32'(stall), 32'h0);
        stepClock();
        checkOutput("raw_busy5", 32'(busy_mask), 32'h0020);
        applyStimulus(1, 8'h05, 2'b01, 6, 1, 1, 0, 0, 0, 0);
        checkOutput("raw_stall", 32'(stall), 32'h1);
        stepClock();
        checkOutput("raw_issue_ignored", 32'(busy_mask), 32'h0020);
        applyStimulus(1, 8'h05, 2'b01, 6, 1, 1, 1, 5, 0, 0);
        checkOutput("raw_no_bypass", 32'(stall), 32'h1);
        stepClock();
        applyStimulus(1, 8'h05, 2'b01, 6, 1, 0, 0, 0, 0, 0);
        checkOutput("raw_released", 32'(stall), 32'h0);
        checkOutput("raw_busy_clear", 32'(busy_mask), 32'h0);

        // Unused source port pointing at a busy register.
        applyStimulus(1, 0, 0, 5, 1, 1, 0, 0, 0, 0);
        stepClock();
        applyStimulus(1, 8'h52, 2'b01, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("unused_src_nostall", 32'(stall), 32'h0);
        applyStimulus(1, 8'h52, 2'b10, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("used_src1_stall", 32'(stall), 32'h1);
        applyStimulus(0, 8'h52, 2'b10, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("invalid_nostall", 32'(stall), 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
        stepClock();
        checkOutput("unused_busy_clear", 32'(busy_mask), 32'h0);

        // Saturation of r7 at three outstanding writes.
        applyStimulus(1, 0, 0, 7, 1, 1, 0, 0, 0, 0);
        stepClock();
        stepClock();
        checkOutput("sat_cnt2_nostall", 32'(stall), 32'h0);
        stepClock();
        checkOutput("sat_stall", 32'(stall), 32'h1);
        checkOutput("sat_busy7", 32'(busy_mask), 32'h0080);
        stepClock();
        checkOutput("sat_hold", 32'(stall), 32'h1);
        applyStimulus(1, 0, 0, 7, 1, 1, 1, 7, 0, 0);
        checkOutput("sat_wb_same_cycle", 32'(stall), 32'h1);
        stepClock();
        applyStimulus(1, 0, 0, 7, 1, 1, 0, 0, 0, 0);
        checkOutput("sat_released", 32'(stall), 32'h0);
        stepClock();
        applyStimulus(1, 0, 0, 7, 1, 0, 0, 0, 0, 0);
        checkOutput("sat_reaccepted", 32'(stall), 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
        stepClock();
        stepClock();
        checkOutput("sat_drain_partial", 32'(busy_mask), 32'h0080);
        stepClock();
        checkOutput("sat_drained", 32'(busy_mask), 32'h0);
        checkOutput("sat_no_err", 32'(err_sticky), 32'h0);

        // Issue, write-back and kill to r4 in the same cycle.
        applyStimulus(1, 0, 0, 4, 1, 1, 0, 0, 0, 0);
        stepClock();
        applyStimulus(1, 0, 0, 4, 1, 1, 1, 4, 0, 0);
        stepClock();
        checkOutput("simul_issue_wb", 32'(busy_mask), 32'h0010);
        applyStimulus(1, 0, 0, 4, 1, 1, 1, 4, 1, 4);
        stepClock();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("simul_issue_wb_kill", 32'(busy_mask), 32'h0);
        checkOutput("simul_no_err", 32'(err_sticky), 32'h0);

        // WAW: a writer of a pending register, with no sources read.
        applyStimulus(1, 0, 0, 2, 1, 1, 0, 0, 0, 0);
        stepClock();
        applyStimulus(1, 0, 0, 2, 1, 0, 0, 0, 0, 0);
        checkOutput("waw_stall", 32'(stall), 32'(WawStallExp));
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        stepClock();
        checkOutput("waw_kill_clear", 32'(busy_mask), 32'h0);

        // Underflow on r9.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
        stepClock();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("ufl_busy", 32'(busy_mask), 32'h0);
        checkOutput("ufl_err", 32'(err_sticky), 32'h1);
        stepClock();
        checkOutput("ufl_err_sticky", 32'(err_sticky), 32'h1);

        // Asynchronous reset mid-traffic with r3 at 2.
        applyStimulus(1, 0, 0, 3, 1, 1, 0, 0, 0, 0);
        stepClock();
        stepClock();
        applyStimulus(1, 8'h03, 2'b01, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mid_busy3", 32'(busy_mask), 32'h0008);
        checkOutput("mid_stall", 32'(stall), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", 32'(busy_mask), 32'h0);
        checkOutput("mid_rst_stall", 32'(stall), 32'h0);
        checkOutput("mid_rst_err", 32'(err_sticky), 32'h0);
        #3;
        rst_n = 1'b1;
        stepClock();
        checkOutput("post_rst_stall", 32'(stall), 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
